win_feed: RTL and testbench

Streaming 4x4 window generator that feeds the 16 data/ctrl input pairs of the first-stage weighted adder. It accepts a raster pixel stream, keeps three line buffers, and emits one 4x4 neighbourhood per accepted pixel once the window is fully inside the frame. It also presents a per-frame 16-entry table of 2-bit weight codes.

---
 rtl/win_feed_pkg.sv | 19 +
 rtl/win_feed_line_buf.sv | 24 ++
 rtl/win_feed.sv | 136 +++++++++++++
 tb/tb_win_feed.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/win_feed_pkg.sv
// Shared types and constants for the win_feed 4x4 window generator.
// The state enum, weight-code encodings and the tap geometry live here.
package win_feed_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_RUN  = 2'd2
  } state_t;

  // Weight codes for the downstream adder; bit 1 alone selects negate.
  localparam logic [1:0] W_NORM = 2'b00;
  localparam logic [1:0] W_X2   = 2'b01;
  localparam logic [1:0] W_NEG  = 2'b10;

  localparam int TAPS  = 16;
  localparam int TAP_W = 8;

endpackage

// File: rtl/win_feed_line_buf.sv
// One line of pixel storage with a single shared read/write address.
// The read is combinational, so it returns the old word before the edge writes the new one.
module line_buf #(
  parameter int DEPTH = 64,
  parameter int WIDTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             wr_en,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  assign rd_data = mem[addr];

  // NOTE: storage arrays carry no reset; rows are always written before any window reads them.
  always_ff @(posedge clock) begin
    if (wr_en) mem[addr] <= wr_data;
  end

endmodule

// File: rtl/win_feed.sv
// Raster-to-4x4 window generator with three line buffers and a per-frame
// weight-code table that is latched from a shadow copy on each sof pixel.
module win_feed
  import win_feed_pkg::*;
#(
  parameter int LINE_W  = 64,
  parameter int FRAME_H = 48
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [TAP_W-1:0]      pix_in,
  input  logic                  pix_valid_in,
  input  logic                  sof_in,
  input  logic                  coef_we_in,
  input  logic [3:0]            coef_addr_in,
  input  logic [1:0]            coef_data_in,
  output logic [TAPS*TAP_W-1:0] win_data_out,
  output logic [TAPS*2-1:0]     win_ctrl_out,
  output logic                  win_valid_out,
  output logic                  frame_done_out,
  output logic                  sof_err_out
);

  localparam int CW = $clog2(LINE_W);
  localparam int RW = $clog2(FRAME_H);

  state_t          state_q, state_d;
  logic [CW-1:0]   col_q, col_d, x;
  logic [RW-1:0]   row_q, row_d, y;
  logic            accept, restart, emit, last;

  logic [TAP_W-1:0] win_q [TAPS];
  logic [TAP_W-1:0] win_d [TAPS];
  logic [TAPS*TAP_W-1:0] win_flat;
  logic [TAP_W-1:0] lb_rd [3];
  logic [TAP_W-1:0] new_col [4];

  logic [1:0] shadow_q [TAPS];
  logic [1:0] active_q [TAPS];

  // lb0 holds row y-1, lb1 row y-2, lb2 row y-3; each cascades into the next.
  line_buf #(.DEPTH(LINE_W), .WIDTH(TAP_W)) u_lb0 (
    .clock(clock), .wr_en(accept), .addr(x), .wr_data(pix_in),   .rd_data(lb_rd[0]));
  line_buf #(.DEPTH(LINE_W), .WIDTH(TAP_W)) u_lb1 (
    .clock(clock), .wr_en(accept), .addr(x), .wr_data(lb_rd[0]), .rd_data(lb_rd[1]));
  line_buf #(.DEPTH(LINE_W), .WIDTH(TAP_W)) u_lb2 (
    .clock(clock), .wr_en(accept), .addr(x), .wr_data(lb_rd[1]), .rd_data(lb_rd[2]));

  // NOTE: every signal driven here gets a default first so no latch is inferred,
  // and combinational logic uses blocking '=' while flops below use '<='.
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    restart = pix_valid_in && sof_in;
    accept  = pix_valid_in && (sof_in || (state_q != S_IDLE));
    x       = restart ? '0 : col_q;
    y       = restart ? '0 : row_q;
    emit    = 1'b0;
    last    = 1'b0;
    if (accept) begin
      emit = (y >= RW'(3)) && (x >= CW'(3));
      last = (x == CW'(LINE_W - 1)) && (y == RW'(FRAME_H - 1));
      if (last) begin
        col_d = '0;
        row_d = '0;
      end else if (x == CW'(LINE_W - 1)) begin
        col_d = '0;
        row_d = y + RW'(1);
      end else begin
        col_d = x + CW'(1);
        row_d = y;
      end
      if (last)                    state_d = S_IDLE;
      else if (row_d >= RW'(3))    state_d = S_RUN;
      else                         state_d = S_FILL;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      col_q   <= '0;
      row_q   <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
    end
  end

  // Column i of the incoming right edge, top (oldest row) to bottom (current pixel).
  assign new_col[0] = lb_rd[2];
  assign new_col[1] = lb_rd[1];
  assign new_col[2] = lb_rd[0];
  assign new_col[3] = pix_in;

  always_comb begin
    win_d = win_q;
    if (accept) begin
      for (int i = 0; i < 4; i++) begin
        for (int j = 0; j < 3; j++) win_d[4*i+j] = win_q[4*i+j+1];
        win_d[4*i+3] = new_col[i];
      end
    end
    win_flat = '0;
    for (int k = 0; k < TAPS; k++) win_flat[TAP_W*k +: TAP_W] = win_d[k];
  end

  always_comb begin
    win_ctrl_out = '0;
    for (int k = 0; k < TAPS; k++) win_ctrl_out[2*k +: 2] = active_q[k];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      win_q          <= '{default: '0};
      shadow_q       <= '{default: W_NORM};
      active_q       <= '{default: W_NORM};
      win_data_out   <= '0;
      win_valid_out  <= 1'b0;
      frame_done_out <= 1'b0;
      sof_err_out    <= 1'b0;
    end else begin
      win_q          <= win_d;
      win_valid_out  <= emit;
      frame_done_out <= accept && last;
      sof_err_out    <= restart && (state_q != S_IDLE);
      if (emit) win_data_out <= win_flat;
      // The copy reads shadow_q before this edge's write lands.
      if (restart) active_q <= shadow_q;
      if (coef_we_in) shadow_q[coef_addr_in] <= coef_data_in;
    end
  end

endmodule

// File: tb/tb_win_feed.sv
// Self-checking bench for win_feed: directed frames plus randomized traffic,
// compared each cycle against a frame-image reference model.
module tb_win_feed;
  import win_feed_pkg::*;

  localparam int LW = 8;
  localparam int FH = 6;

  logic         clock = 1'b0;
  logic         reset;
  logic [7:0]   pix_in;
  logic         pix_valid_in, sof_in, coef_we_in;
  logic [3:0]   coef_addr_in;
  logic [1:0]   coef_data_in;
  logic [127:0] win_data_out;
  logic [31:0]  win_ctrl_out;
  logic         win_valid_out, frame_done_out, sof_err_out;

  win_feed #(.LINE_W(LW), .FRAME_H(FH)) dut (
    .clock(clock), .reset(reset), .pix_in(pix_in), .pix_valid_in(pix_valid_in),
    .sof_in(sof_in), .coef_we_in(coef_we_in), .coef_addr_in(coef_addr_in),
    .coef_data_in(coef_data_in), .win_data_out(win_data_out), .win_ctrl_out(win_ctrl_out),
    .win_valid_out(win_valid_out), .frame_done_out(frame_done_out), .sof_err_out(sof_err_out));

  always #5 clock = ~clock;

  // Reference model: the received frame as a 2-D image plus the raster position.
  logic [7:0]   img [FH][LW];
  bit           m_busy;
  int           m_row, m_col;
  logic [1:0]   m_shadow [16];
  logic [1:0]   m_active [16];
  logic [127:0] e_data;
  logic         e_valid, e_done, e_err;

  int vectors = 0;
  int miscompares = 0;
  int dut_pulses = 0;
  int dut_dones = 0;

  function automatic logic [31:0] model_ctrl();
    logic [31:0] c = '0;
    for (int k = 0; k < 16; k++) c[2*k +: 2] = m_active[k];
    return c;
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic compare_all();
    check("valid", 128'(win_valid_out), 128'(e_valid));
    check("data", win_data_out, e_data);
    check("ctrl", 128'(win_ctrl_out), 128'(model_ctrl()));
    check("done", 128'(frame_done_out), 128'(e_done));
    check("sof_err", 128'(sof_err_out), 128'(e_err));
  endtask

  task automatic step(input logic [7:0] p, input logic v, input logic s,
                      input logic we = 1'b0, input logic [3:0] a = 4'd0,
                      input logic [1:0] d = 2'b00);
    bit acc;
    int yy, xx;
    pix_in = p; pix_valid_in = v; sof_in = s;
    coef_we_in = we; coef_addr_in = a; coef_data_in = d;
    @(posedge clock);
    #1;
    e_valid = 1'b0; e_done = 1'b0; e_err = 1'b0;
    acc = 1'b0;
    if (v) begin
      if (s) begin
        e_err = m_busy;
        for (int k = 0; k < 16; k++) m_active[k] = m_shadow[k];
        m_busy = 1'b1; m_row = 0; m_col = 0; acc = 1'b1;
      end else if (m_busy) begin
        acc = 1'b1;
      end
    end
    if (acc) begin
      yy = m_row; xx = m_col;
      img[yy][xx] = p;
      if (yy >= 3 && xx >= 3) begin
        e_valid = 1'b1;
        for (int i = 0; i < 4; i++)
          for (int j = 0; j < 4; j++)
            e_data[8*(4*i+j) +: 8] = img[yy-3+i][xx-3+j];
      end
      if (xx == LW - 1) begin
        m_col = 0;
        if (yy == FH - 1) begin
          m_row = 0; m_busy = 1'b0; e_done = 1'b1;
        end else begin
          m_row = yy + 1;
        end
      end else begin
        m_col = xx + 1;
      end
    end
    if (we) m_shadow[a] = d;
    if (win_valid_out) dut_pulses++;
    if (frame_done_out) dut_dones++;
    compare_all();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    pix_in = '0; pix_valid_in = 1'b0; sof_in = 1'b0;
    coef_we_in = 1'b0; coef_addr_in = '0; coef_data_in = '0;
    @(posedge clock);
    #1;
    reset = 1'b0;
    m_busy = 1'b0; m_row = 0; m_col = 0;
    for (int k = 0; k < 16; k++) begin m_shadow[k] = W_NORM; m_active[k] = W_NORM; end
    e_data = '0; e_valid = 1'b0; e_done = 1'b0; e_err = 1'b0;
    compare_all();
  endtask

  // Full frame of 8y+x pixels; optional idle cycle after every pixel.
  task automatic run_frame(input bit gap, input string tag);
    int p0 = dut_pulses;
    for (int n = 0; n < LW * FH; n++) begin
      step(8'(n), 1'b1, n == 0);
      if (n == 27) begin
        check({tag, "_first_valid"}, 128'(win_valid_out), 128'(1));
        check({tag, "_first_tap0"}, 128'(win_data_out[7:0]), 128'(0));
        check({tag, "_first_tap5"}, 128'(win_data_out[47:40]), 128'(9));
        check({tag, "_first_tap15"}, 128'(win_data_out[127:120]), 128'(27));
      end
      if (n == LW * FH - 1) begin
        check({tag, "_last_tap15"}, 128'(win_data_out[127:120]), 128'(47));
        check({tag, "_last_tap0"}, 128'(win_data_out[7:0]), 128'(20));
        check({tag, "_last_done"}, 128'(frame_done_out), 128'(1));
      end
      if (gap) step(8'($urandom), 1'b0, 1'b0);
    end
    check({tag, "_pulses"}, 128'(dut_pulses - p0), 128'(15));
  endtask

  initial begin
    int p0, d0, first, guard;
    do_reset();

    // Continuous single frame.
    run_frame(1'b0, "s1");

    // Same frame with idle gaps.
    run_frame(1'b1, "s2");

    // Pixels before any sof are discarded.
    p0 = dut_pulses; d0 = dut_dones;
    for (int n = 0; n < 10; n++) step(8'(n), 1'b1, 1'b0);
    check("s3_no_windows", 128'(dut_pulses - p0), 128'(0));
    check("s3_no_done", 128'(dut_dones - d0), 128'(0));
    run_frame(1'b0, "s3");

    // Shadow writes mid-frame stay invisible until the next sof.
    for (int n = 0; n < LW * FH; n++)
      step(8'(n), 1'b1, n == 0, (n == 10) || (n == 20),
           (n == 10) ? 4'd0 : 4'd15, (n == 10) ? W_NEG : W_X2);
    check("s4_ctrl_held", 128'(win_ctrl_out), 128'(0));
    run_frame(1'b0, "s4");
    check("s4_ctrl_loaded", 128'(win_ctrl_out), 128'(32'h4000_0002));

    // sof at pixel 30 abandons the frame.
    for (int n = 0; n < 30; n++) step(8'(n), 1'b1, n == 0);
    step(8'(30), 1'b1, 1'b1);
    check("s5_err", 128'(sof_err_out), 128'(1));
    check("s5_no_win", 128'(win_valid_out), 128'(0));
    first = -1;
    for (int n = 1; n < LW * FH; n++) begin
      step(8'(n), 1'b1, 1'b0);
      if (win_valid_out && first < 0) first = n;
    end
    check("s5_next_win", 128'(first), 128'(27));

    // Reset mid-frame, then a clean frame.
    for (int n = 0; n < 35; n++) step(8'(n), 1'b1, n == 0);
    do_reset();
    run_frame(1'b0, "s6");

    // Randomized traffic: random pixels, gaps, coefficient writes and rare restarts.
    for (int f = 0; f < 3; f++) begin
      step(8'($urandom), 1'b1, 1'b1, 1'($urandom), 4'($urandom), 2'($urandom));
      guard = 0;
      while (m_busy && guard < 1000) begin
        step(8'($urandom), $urandom_range(0, 9) < 7, $urandom_range(0, 199) == 0,
             $urandom_range(0, 9) == 0, 4'($urandom), 2'($urandom));
        guard++;
      end
      check("rnd_frame_end", 128'(m_busy), 128'(0));
    end
    // Coefficient write coincident with sof: the copy sees the old shadow.
    step(8'd1, 1'b1, 1'b1, 1'b1, 4'd3, W_X2);
    step(8'd2, 1'b1, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
